mc_control_unit: RTL and testbench

Parametrised multicycle control FSM for the RV32I core, sequencing fetch, decode, execute, memory and writeback over a request/acknowledge memory port with variable latency. It extends the fixed-latency controller with conditional branches, illegal-opcode and SYSTEM trapping, a memory-wait timeout, and a registered trap cause. It sits between the instruction register/ALU flags and the datapath muxes/enables, one instance per hart.

---
 rtl/ctrl_pkg.sv | 63 ++++++
 rtl/mc_wait_timer.sv | 45 ++++
 rtl/mc_control_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// +-----------------------------------------------------------------------------
// | ctrl_pkg : shared opcode, datapath-select, state and trap-cause encodings
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package ctrl_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  localparam logic       ADDR_PC_OUT  = 1'b0;
  localparam logic       ADDR_ALU_OUT = 1'b1;

  localparam logic [1:0] REG_SRC_ALU  = 2'd1;
  localparam logic [1:0] REG_SRC_MEM  = 2'd2;
  localparam logic [1:0] REG_SRC_PC   = 2'd3;

  localparam logic [1:0] SRCA_RS1     = 2'd1;
  localparam logic [1:0] SRCA_CURR_PC = 2'd2;
  localparam logic [1:0] SRCA_OLD_PC  = 2'd3;

  localparam logic [1:0] SRCB_RS2     = 2'd1;
  localparam logic [1:0] SRCB_IMMED   = 2'd2;
  localparam logic [1:0] SRCB_FOUR    = 2'd3;

  localparam logic [1:0] ALU_ADD      = 2'd0;
  localparam logic [1:0] ALU_FUNCT    = 2'd1;
  localparam logic [1:0] ALU_BRANCH   = 2'd2;
  localparam logic [1:0] ALU_PASS_B   = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_BR_TGT  = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    TRAP_NONE    = 3'd0,
    TRAP_ILLEGAL = 3'd1,
    TRAP_MEM_ERR = 3'd2,
    TRAP_TIMEOUT = 3'd3,
    TRAP_EXT_ERR = 3'd4,
    TRAP_SYSTEM  = 3'd5
  } trap_cause_e;

endpackage

`default_nettype wire

// File: rtl/mc_wait_timer.sv
// +-----------------------------------------------------------------------------
// | mc_wait_timer : counts unacknowledged request cycles, flags memory timeout
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic req_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int CW = 16;
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || ack_i) begin
      cnt_d = '0;
    end else if (req_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Fires in the MEM_TIMEOUT-th waiting cycle; an ack in that same cycle wins.
  assign timeout_o = req_i && !ack_i && (cnt_q >= LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_unit.sv
// +-----------------------------------------------------------------------------
// | mc_control_unit : multicycle RV32I control FSM with traps and memory timeout
// | Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ack,
  input  logic             mem_err,
  input  logic             error,
  output logic             mem_req,
  output logic             pcUpdate,
  output logic             irWrite,
  output logic             addrSrc,
  output logic             memWrite,
  output logic             memRead,
  output logic             regWrite,
  output logic [1:0]       regSrc,
  output logic [1:0]       aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluCtrl,
  output logic             halted,
  output logic [2:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  state_e      state_q, state_d;
  trap_cause_e trap_cause_q, trap_cause_d, halt_cause;
  logic        halted_q;
  logic        req_active;
  logic        timeout;
  logic        timer_clr;

  // Kept separate from mem_req so the timer path does not loop through the FSM block.
  assign req_active = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timer_clr  = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));

  mc_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (timer_clr),
    .req_i    (req_active),
    .ack_i    (mem_ack && req_active),
    .timeout_o(timeout)
  );

  always_comb begin
    mem_req    = 1'b0;
    pcUpdate   = 1'b0;
    irWrite    = 1'b0;
    addrSrc    = ADDR_PC_OUT;
    memWrite   = 1'b0;
    memRead    = 1'b0;
    regWrite   = 1'b0;
    regSrc     = 2'd0;
    aluSrcA    = 2'd0;
    aluSrcB    = 2'd0;
    aluCtrl    = 2'd0;
    state_d    = state_q;
    halt_cause = TRAP_NONE;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        memRead = 1'b1;
        addrSrc = ADDR_PC_OUT;
        if (mem_ack) state_d = S_DECODE;
      end
      S_DECODE: begin
        irWrite  = 1'b1;
        pcUpdate = 1'b1;
        aluSrcA  = SRCA_CURR_PC;
        aluSrcB  = SRCB_FOUR;
        aluCtrl  = ALU_ADD;
        state_d  = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        case (opcode)
          OPC_LUI: begin
            aluSrcB  = SRCB_IMMED;
            aluCtrl  = ALU_PASS_B;
            regSrc   = REG_SRC_ALU;
            regWrite = 1'b1;
          end
          OPC_AUIPC: begin
            aluSrcA  = SRCA_OLD_PC;
            aluSrcB  = SRCB_IMMED;
            aluCtrl  = ALU_ADD;
            regSrc   = REG_SRC_ALU;
            regWrite = 1'b1;
          end
          OPC_JAL: begin
            aluSrcA  = SRCA_OLD_PC;
            aluSrcB  = SRCB_IMMED;
            aluCtrl  = ALU_ADD;
            regSrc   = REG_SRC_PC;
            pcUpdate = 1'b1;
            regWrite = 1'b1;
          end
          OPC_JALR: begin
            aluSrcA  = SRCA_RS1;
            aluSrcB  = SRCB_IMMED;
            aluCtrl  = ALU_ADD;
            regSrc   = REG_SRC_PC;
            pcUpdate = 1'b1;
            regWrite = 1'b1;
          end
          OPC_OP_IMM: begin
            aluSrcA  = SRCA_RS1;
            aluSrcB  = SRCB_IMMED;
            aluCtrl  = ALU_FUNCT;
            regSrc   = REG_SRC_ALU;
            regWrite = 1'b1;
          end
          OPC_OP: begin
            aluSrcA  = SRCA_RS1;
            aluSrcB  = SRCB_RS2;
            aluCtrl  = ALU_FUNCT;
            regSrc   = REG_SRC_ALU;
            regWrite = 1'b1;
          end
          OPC_LOAD, OPC_STORE: begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_IMMED;
            aluCtrl = ALU_ADD;
            state_d = S_MEM;
          end
          OPC_BRANCH: begin
            aluSrcA = SRCA_RS1;
            aluSrcB = SRCB_RS2;
            aluCtrl = ALU_BRANCH;
            state_d = branch_taken ? S_BR_TGT : S_FETCH;
          end
          OPC_SYSTEM: begin
            state_d    = S_HALT;
            halt_cause = TRAP_SYSTEM;
          end
          default: begin
            state_d    = S_HALT;
            halt_cause = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        addrSrc = ADDR_ALU_OUT;
        if (opcode == OPC_STORE) memWrite = 1'b1;
        else                     memRead  = 1'b1;
        if (mem_ack) state_d = (opcode == OPC_STORE) ? S_FETCH : S_WB;
      end
      S_WB: begin
        regSrc   = REG_SRC_MEM;
        regWrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BR_TGT: begin
        aluSrcA  = SRCA_OLD_PC;
        aluSrcB  = SRCB_IMMED;
        aluCtrl  = ALU_ADD;
        pcUpdate = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Trap priority: external error, then bus error on a live request, then timeout.
    if (state_q != S_HALT) begin
      if (error) begin
        state_d    = S_HALT;
        halt_cause = TRAP_EXT_ERR;
      end else if (mem_err && req_active) begin
        state_d    = S_HALT;
        halt_cause = TRAP_MEM_ERR;
      end else if (timeout) begin
        state_d    = S_HALT;
        halt_cause = TRAP_TIMEOUT;
      end
    end
  end

  assign trap_cause_d = ((state_q != S_HALT) && (state_d == S_HALT)) ? halt_cause : trap_cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      trap_cause_q <= TRAP_NONE;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      halted_q     <= (state_d == S_HALT);
    end
  end

  assign halted     = halted_q;
  assign trap_cause = trap_cause_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             retire;

  assign retire = (state_d == S_FETCH) &&
                  ((state_q == S_EXECUTE) || (state_q == S_WB) ||
                   (state_q == S_BR_TGT)  || (state_q == S_MEM));

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q   <= cycle_q + CNT_W'(1);
      if (retire)            instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mc_control_unit.sv
// +-----------------------------------------------------------------------------
// | tb_mc_control_unit : scoreboard bench for the multicycle control FSM
// | Revision : 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_unit;
  import ctrl_pkg::*;

  localparam int CNT_W = 32;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, rst;
  logic [6:0] opcode;
  logic branch_taken, mem_ack, mem_err, error;
  logic mem_req, pcUpdate, irWrite, addrSrc, memWrite, memRead, regWrite;
  logic [1:0] regSrc, aluSrcA, aluSrcB, aluCtrl;
  logic halted;
  logic [2:0] trap_cause;
  logic [CNT_W-1:0] cycle_count, instret_count;

  mc_control_unit #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .branch_taken (branch_taken),
    .mem_ack      (mem_ack),
    .mem_err      (mem_err),
    .error        (error),
    .mem_req      (mem_req),
    .pcUpdate     (pcUpdate),
    .irWrite      (irWrite),
    .addrSrc      (addrSrc),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .regWrite     (regWrite),
    .regSrc       (regSrc),
    .aluSrcA      (aluSrcA),
    .aluSrcB      (aluSrcB),
    .aluCtrl      (aluCtrl),
    .halted       (halted),
    .trap_cause   (trap_cause),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {mem_req, pcUpdate, irWrite, addrSrc, memWrite, memRead, regWrite,
                regSrc, aluSrcA, aluSrcB, aluCtrl, halted, trap_cause};

  typedef struct {
    string       tag;
    logic [18:0] v;
  } sb_t;
  sb_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] ov(input logic mreq, pcu, irw, asrc, mw, mr, rw,
                                     input logic [1:0] rs, sa, sb, ac,
                                     input logic h, input logic [2:0] tc);
    return {mreq, pcu, irw, asrc, mw, mr, rw, rs, sa, sb, ac, h, tc};
  endfunction

  function automatic logic [63:0] pexp(input int v);
    return PERF ? 64'(v) : 64'd0;
  endfunction

  logic [18:0] v_fetch, v_decode, v_ex_op, v_ex_ls, v_mem_ld, v_mem_st, v_wb;
  logic [18:0] v_ex_br, v_brt, v_ex_jal, v_ex_lui, v_zero;

  function automatic logic [18:0] v_halt(input logic [2:0] c);
    return ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 1'b1, c);
  endfunction

  // Expected outputs are queued as stimulus is applied and compared mid-cycle.
  task automatic drive(input string tag, input logic [6:0] op, input logic ack, br,
                       merr, err, input logic [18:0] expv);
    sb_t e;
    opcode = op; mem_ack = ack; branch_taken = br; mem_err = merr; error = err;
    sb_q.push_back('{tag, expv});
    @(negedge clk);
    e = sb_q.pop_front();
    chk(e.tag, 64'(obs), 64'(e.v));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    opcode = 7'd0; mem_ack = 1'b0; branch_taken = 1'b0; mem_err = 1'b0; error = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    v_fetch  = ov(1,0,0,ADDR_PC_OUT,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0, 3'd0);
    v_decode = ov(0,1,1,0,0,0,0, 2'd0,SRCA_CURR_PC,SRCB_FOUR,ALU_ADD, 0, 3'd0);
    v_ex_op  = ov(0,0,0,0,0,0,1, REG_SRC_ALU,SRCA_RS1,SRCB_RS2,ALU_FUNCT, 0, 3'd0);
    v_ex_ls  = ov(0,0,0,0,0,0,0, 2'd0,SRCA_RS1,SRCB_IMMED,ALU_ADD, 0, 3'd0);
    v_mem_ld = ov(1,0,0,ADDR_ALU_OUT,0,1,0, 2'd0,2'd0,2'd0,2'd0, 0, 3'd0);
    v_mem_st = ov(1,0,0,ADDR_ALU_OUT,1,0,0, 2'd0,2'd0,2'd0,2'd0, 0, 3'd0);
    v_wb     = ov(0,0,0,0,0,0,1, REG_SRC_MEM,2'd0,2'd0,2'd0, 0, 3'd0);
    v_ex_br  = ov(0,0,0,0,0,0,0, 2'd0,SRCA_RS1,SRCB_RS2,ALU_BRANCH, 0, 3'd0);
    v_brt    = ov(0,1,0,0,0,0,0, 2'd0,SRCA_OLD_PC,SRCB_IMMED,ALU_ADD, 0, 3'd0);
    v_ex_jal = ov(0,1,0,0,0,0,1, REG_SRC_PC,SRCA_OLD_PC,SRCB_IMMED,ALU_ADD, 0, 3'd0);
    v_ex_lui = ov(0,0,0,0,0,0,1, REG_SRC_ALU,2'd0,SRCB_IMMED,ALU_PASS_B, 0, 3'd0);
    v_zero   = ov(0,0,0,0,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0, 3'd0);

    do_reset();
    do_reset();
    chk("rst_cycle", 64'(cycle_count), 64'd0);
    chk("rst_instret", 64'(instret_count), 64'd0);

    // OP, zero-wait memory: writeback in cycle 3
    drive("op_fetch",  OPC_OP, 1,0,0,0, v_fetch);
    drive("op_decode", OPC_OP, 0,0,0,0, v_decode);
    drive("op_exec",   OPC_OP, 0,0,0,0, v_ex_op);
    chk("op_cycles",  64'(cycle_count),   pexp(3));
    chk("op_instret", 64'(instret_count), pexp(1));

    // LOAD with 3 wait cycles in FETCH (ack on the timeout cycle) and 2 in MEM
    for (int i = 0; i < 3; i++) drive("ld_fetch_wait", OPC_LOAD, 0,0,0,0, v_fetch);
    drive("ld_fetch_ack", OPC_LOAD, 1,0,0,0, v_fetch);
    drive("ld_decode",    OPC_LOAD, 0,0,0,0, v_decode);
    drive("ld_exec",      OPC_LOAD, 0,0,0,0, v_ex_ls);
    for (int i = 0; i < 2; i++) drive("ld_mem_wait", OPC_LOAD, 0,0,0,0, v_mem_ld);
    drive("ld_mem_ack",   OPC_LOAD, 1,0,0,0, v_mem_ld);
    drive("ld_wb",        OPC_LOAD, 0,0,0,0, v_wb);
    chk("ld_cycles",  64'(cycle_count),   pexp(13));
    chk("ld_instret", 64'(instret_count), pexp(2));

    drive("st_fetch",  OPC_STORE, 1,0,0,0, v_fetch);
    drive("st_decode", OPC_STORE, 0,0,0,0, v_decode);
    drive("st_exec",   OPC_STORE, 0,0,0,0, v_ex_ls);
    drive("st_mem",    OPC_STORE, 1,0,0,0, v_mem_st);
    chk("st_cycles",  64'(cycle_count),   pexp(17));
    chk("st_instret", 64'(instret_count), pexp(3));

    drive("brt_fetch",  OPC_BRANCH, 1,1,0,0, v_fetch);
    drive("brt_decode", OPC_BRANCH, 0,1,0,0, v_decode);
    drive("brt_exec",   OPC_BRANCH, 0,1,0,0, v_ex_br);
    drive("brt_target", OPC_BRANCH, 0,1,0,0, v_brt);
    chk("brt_cycles",  64'(cycle_count),   pexp(21));
    chk("brt_instret", 64'(instret_count), pexp(4));

    drive("brn_fetch",  OPC_BRANCH, 1,0,0,0, v_fetch);
    drive("brn_decode", OPC_BRANCH, 0,0,0,0, v_decode);
    drive("brn_exec",   OPC_BRANCH, 0,0,0,0, v_ex_br);
    chk("brn_cycles",  64'(cycle_count),   pexp(24));
    chk("brn_instret", 64'(instret_count), pexp(5));
    drive("brn_back_fetch", OPC_BRANCH, 0,0,0,0, v_fetch);

    drive("jal_fetch",  OPC_JAL, 1,0,0,0, v_fetch);
    drive("jal_decode", OPC_JAL, 0,0,0,0, v_decode);
    drive("jal_exec",   OPC_JAL, 0,0,0,0, v_ex_jal);
    chk("jal_instret", 64'(instret_count), pexp(6));
    drive("lui_fetch",  OPC_LUI, 1,0,0,0, v_fetch);
    drive("lui_decode", OPC_LUI, 0,0,0,0, v_decode);
    drive("lui_exec",   OPC_LUI, 0,0,0,0, v_ex_lui);
    chk("lui_cycles",  64'(cycle_count),   pexp(31));
    chk("lui_instret", 64'(instret_count), pexp(7));

    // Illegal opcode traps; noisy inputs in HALT must not disturb the first cause
    drive("ill_fetch",  7'd0, 1,0,0,0, v_fetch);
    drive("ill_decode", 7'd0, 0,0,0,0, v_decode);
    drive("ill_exec",   7'd0, 0,0,0,0, v_zero);
    for (int i = 0; i < 20; i++) drive("ill_halt", 7'd0, 1,1,1,1, v_halt(TRAP_ILLEGAL));
    chk("halt_cycles",  64'(cycle_count),   pexp(34));
    chk("halt_instret", 64'(instret_count), pexp(7));

    // Reset abandons a pending MEM request; then FETCH times out after 4 waits
    do_reset();
    drive("rm_fetch",  OPC_LOAD, 1,0,0,0, v_fetch);
    drive("rm_decode", OPC_LOAD, 0,0,0,0, v_decode);
    drive("rm_exec",   OPC_LOAD, 0,0,0,0, v_ex_ls);
    drive("rm_wait",   OPC_LOAD, 0,0,0,0, v_mem_ld);
    rst = 1'b1;
    drive("rm_rst",    OPC_LOAD, 0,0,0,0, v_mem_ld);
    rst = 1'b0;
    chk("rm_cycles",  64'(cycle_count),   64'd0);
    chk("rm_instret", 64'(instret_count), 64'd0);
    chk("rm_trap",    64'(trap_cause),    64'd0);
    for (int i = 0; i < 4; i++) drive("to_wait", OPC_LOAD, 0,0,0,0, v_fetch);
    drive("to_halt", OPC_LOAD, 0,0,0,0, v_halt(TRAP_TIMEOUT));

    do_reset();
    drive("err_both", OPC_OP, 0,0,1,1, v_fetch);
    drive("err_halt", OPC_OP, 0,0,0,0, v_halt(TRAP_EXT_ERR));

    do_reset();
    drive("merr_fetch",  OPC_STORE, 1,0,0,0, v_fetch);
    drive("merr_decode", OPC_STORE, 0,0,0,0, v_decode);
    drive("merr_exec",   OPC_STORE, 0,0,0,0, v_ex_ls);
    drive("merr_mem",    OPC_STORE, 0,0,1,0, v_mem_st);
    drive("merr_halt",   OPC_STORE, 0,0,0,0, v_halt(TRAP_MEM_ERR));

    // mem_err without a live request is ignored
    do_reset();
    drive("sys_fetch",  OPC_SYSTEM, 1,0,0,0, v_fetch);
    drive("sys_decode", OPC_SYSTEM, 0,0,1,0, v_decode);
    drive("sys_exec",   OPC_SYSTEM, 0,0,0,0, v_zero);
    drive("sys_halt",   OPC_SYSTEM, 0,0,0,0, v_halt(TRAP_SYSTEM));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
